// File: rtl/uart_pkg.sv
// Shared widths, entry layout and packing helper for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_FLAG_W  = 4;
  localparam int UART_ENTRY_W = 12;

  localparam int BE_BIT = 8;
  localparam int OE_BIT = 9;
  localparam int PE_BIT = 10;
  localparam int FE_BIT = 11;

  // Field order places BE at bit 8 through FE at bit 11.
  typedef struct packed {
    logic                   fe;
    logic                   pe;
    logic                   oe;
    logic                   be;
    logic [UART_DATA_W-1:0] data;
  } uart_entry_t;

  // flags is {FE,PE,OE,BE}.
  function automatic uart_entry_t make_entry(input logic [UART_FLAG_W-1:0] flags,
                                             input logic [UART_DATA_W-1:0] data);
    uart_entry_t e;
    e.fe   = flags[FE_BIT-UART_DATA_W];
    e.pe   = flags[PE_BIT-UART_DATA_W];
    e.oe   = flags[OE_BIT-UART_DATA_W];
    e.be   = flags[BE_BIT-UART_DATA_W];
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/uart_sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
module uart_sync_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_ENTRY_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between reads; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive frame buffer with back-pressure, sticky over/underflow flags and saturating error counters.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STOP_MARGIN = 2,
  parameter int CNT_W       = 8,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                    UART_clk,
  input  logic                    rst,
  input  logic [UART_DATA_W-1:0]  rx_data,
  input  logic                    rx_done_tick,
  input  logic                    BE,
  input  logic                    OE,
  input  logic                    PE,
  input  logic                    FE,
  output logic                    rx_stop,
  input  logic                    rd_en,
  output logic [UART_ENTRY_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    full,
  output logic [LVL_W-1:0]        level,
  output logic                    ovf,
  output logic                    udf,
  output logic [CNT_W-1:0]        be_cnt,
  output logic [CNT_W-1:0]        oe_cnt,
  output logic [CNT_W-1:0]        pe_cnt,
  output logic [CNT_W-1:0]        fe_cnt,
  input  logic                    clr_stat
);

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LVL_W-1:0]       next_level;
  logic [UART_FLAG_W-1:0] flags;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [CNT_W-1:0]       cnt [UART_FLAG_W];
  uart_entry_t            wr_entry;

  assign flags    = {FE, PE, OE, BE};
  assign wr_entry = make_entry(flags, rx_data);
  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));

  // A full FIFO still accepts a frame when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = rx_done_tick && (!full || rd_acc);

  always_comb begin
    next_level = level;
    if (wr_acc && !rd_acc)      next_level = level + 1'b1;
    else if (rd_acc && !wr_acc) next_level = level - 1'b1;
  end

  uart_sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (UART_ENTRY_W)
  ) u_mem (
    .clk     (UART_clk),
    .rst     (rst),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .re      (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge UART_clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rx_stop  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      level    <= next_level;
      rd_valid <= rd_acc;
      rx_stop  <= (next_level >= LVL_W'(DEPTH - STOP_MARGIN));
    end
  end

  // clr_stat takes priority over any overflow, underflow or tick in the same cycle.
  always_ff @(posedge UART_clk) begin
    if (rst || clr_stat) begin
      ovf <= 1'b0;
      udf <= 1'b0;
      for (int i = 0; i < UART_FLAG_W; i++) cnt[i] <= '0;
    end else begin
      if (rx_done_tick && !wr_acc) ovf <= 1'b1;
      if (rd_en && empty)          udf <= 1'b1;
      for (int i = 0; i < UART_FLAG_W; i++) begin
        if (rx_done_tick && flags[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign be_cnt = cnt[0];
  assign oe_cnt = cnt[1];
  assign pe_cnt = cnt[2];
  assign fe_cnt = cnt[3];

endmodule
